dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t      : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W       : data/address word width
//   CNT_W        : wait-state counter width (LATENCY range 0..15)
//   idx_bits()   : log2 of the RAM depth, which sets the word-index width
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bits needed to index 'depth' words (depth is a power of two).
  function automatic int idx_bits(input int depth);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(depth)) begin
        b = i + 1;
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: EX/MEM-to-responder bus.
//   Request (pipeline -> responder): MemRead_i, MemWrite_i, Addr_i, Data_i
//   Response (responder -> pipeline): Stall_o, Ack_o, ReadData_o, Misalign_o
//   modport master: pipeline side; modport slave: responder side.
interface dmem_if;
  import dmem_pkg::*;

  logic              MemRead_i;
  logic              MemWrite_i;
  logic [WORD_W-1:0] Addr_i;
  logic [WORD_W-1:0] Data_i;
  logic              Stall_o;
  logic              Ack_o;
  logic [WORD_W-1:0] ReadData_o;
  logic              Misalign_o;

  modport master (
    output MemRead_i, MemWrite_i, Addr_i, Data_i,
    input  Stall_o, Ack_o, ReadData_o, Misalign_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, Addr_i, Data_i,
    output Stall_o, Ack_o, ReadData_o, Misalign_o
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, DEPTH_WORDS x WORD_W.
//   clk_i   : clock
//   we_i    : write enable (write addr_i with wdata_i on the edge)
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read of addr_i (old contents on a write edge)
// Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Storage write and registered read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: services EX/MEM loads/stores against an internal RAM with
// LATENCY wait states, stalling the pipeline until the access completes.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : dmem_if.slave (MemRead_i, MemWrite_i, Addr_i, Data_i in;
//             Stall_o, Ack_o, ReadData_o, Misalign_o out)
// Optional: define DMEM_HIT_BYPASS_EN to add a one-entry buffer of the last
// completed access; a load hitting it answers after a single stall cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  dmem_if.slave bus
);

  localparam int AW = idx_bits(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              store_q, store_d;
  logic              ack_q, ack_d;
  logic              mis_q, mis_d;

  logic              req;
  logic              aligned;
  logic [AW-1:0]     in_idx;
  logic              commit;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_rdata;
  logic              byp_hit;
  logic [WORD_W-1:0] byp_data;

  assign req     = bus.MemRead_i | bus.MemWrite_i;
  assign aligned = (bus.Addr_i[1:0] == 2'b00);
  assign in_idx  = bus.Addr_i[AW+1:2];

  // In IDLE the RAM reads the incoming index so that with LATENCY=0 the
  // load data is already on ram_rdata in the single WAIT cycle.
  assign ram_addr = (state_q == IDLE) ? in_idx : idx_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

`ifdef DMEM_HIT_BYPASS_EN
  logic              byp_v_q, byp_v_d;
  logic [AW-1:0]     byp_idx_q, byp_idx_d;
  logic [WORD_W-1:0] byp_data_q, byp_data_d;

  // Only pure loads may bypass; a store (or store+load) always waits.
  assign byp_hit  = bus.MemRead_i & ~bus.MemWrite_i & byp_v_q & (byp_idx_q == in_idx);
  assign byp_data = byp_data_q;

  // Buffer tracks the last committed access so it always mirrors the RAM.
  always_comb begin
    byp_v_d    = byp_v_q;
    byp_idx_d  = byp_idx_q;
    byp_data_d = byp_data_q;
    if (commit) begin
      byp_v_d    = 1'b1;
      byp_idx_d  = idx_q;
      byp_data_d = store_q ? wdata_q : ram_rdata;
    end else begin
      byp_v_d    = byp_v_q;
    end
  end

  // Bypass buffer registers; valid clears on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      byp_v_q    <= 1'b0;
      byp_idx_q  <= {AW{1'b0}};
      byp_data_q <= {WORD_W{1'b0}};
    end else begin
      byp_v_q    <= byp_v_d;
      byp_idx_q  <= byp_idx_d;
      byp_data_q <= byp_data_d;
    end
  end
`else
  assign byp_hit  = 1'b0;
  assign byp_data = {WORD_W{1'b0}};
`endif

  // Next-state, counter, request capture and response computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    store_d = store_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    commit  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && aligned) begin
          // Capture everything now: the request must not matter after T.
          idx_d   = in_idx;
          wdata_d = bus.Data_i;
          store_d = bus.MemWrite_i;
          cnt_d   = CNT_W'(LATENCY);
          if (byp_hit) begin
            state_d = RESP;
            rdata_d = byp_data;
          end else begin
            state_d = WAIT;
          end
        end else if (req) begin
          mis_d = 1'b1;
        end else begin
          mis_d = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = RESP;
          if (store_q) begin
            ram_we = 1'b1;
          end else begin
            rdata_d = ram_rdata;
          end
        end
      end
      RESP: begin
        // Inputs still show the finished request here; ignore them.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ack_d = (state_d == RESP);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {AW{1'b0}};
      wdata_q <= {WORD_W{1'b0}};
      store_q <= 1'b0;
      rdata_q <= {WORD_W{1'b0}};
      ack_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      mis_q   <= mis_d;
    end
  end

  // Stall is combinational so the pipeline freezes in the request cycle;
  // it is forced low while reset is held.
  assign bus.Stall_o    = rst_n_i & (((state_q == IDLE) & req & aligned) | (state_q == WAIT));
  assign bus.Ack_o      = ack_q;
  assign bus.ReadData_o = rdata_q;
  assign bus.Misalign_o = mis_q;

endmodule
